// File: rtl/sysid_regs_if.sv
// Avalon-MM control-port bundle for sysid_regs: word address, single-cycle
// read/write strobes, and registered read data returned with readdatavalid.
interface sysid_regs_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, writedata,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/sysid_regs.sv
// System-identification slave: ID/timestamp/caps words, 64-bit uptime with
// atomic high-word snapshot, scratch bank. Scratch write lock via SYSID_SCRATCH_LOCK_EN.
module sysid_regs #(
   parameter logic [31:0] SYSTEM_ID   = 32'h0000_0001,
   parameter logic [31:0] TIMESTAMP   = 32'h56A6_A3EC,
   parameter int          NUM_SCRATCH = 4,
   parameter int          ADDR_W      = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   sysid_regs_if.slave bus
);

   localparam logic [31:0] A_ID      = 32'd0;
   localparam logic [31:0] A_TS      = 32'd1;
   localparam logic [31:0] A_UP_LO   = 32'd2;
   localparam logic [31:0] A_UP_HI   = 32'd3;
   localparam logic [31:0] A_CAPS    = 32'd4;
   localparam logic [31:0] A_CLR     = 32'd5;
   localparam logic [31:0] A_LOCK    = 32'd6;
   localparam logic [31:0] A_SCR     = 32'd8;
   localparam logic [31:0] UNLOCK_KEY = 32'h4C4F_434B;

`ifdef SYSID_SCRATCH_LOCK_EN
   localparam logic LOCK_FEATURE = 1'b1;
`else
   localparam logic LOCK_FEATURE = 1'b0;
`endif

   localparam logic [31:0] CAPS_WORD = {16'h0, 8'(NUM_SCRATCH), 7'h0, LOCK_FEATURE};

   generate
      if (NUM_SCRATCH < 1 || NUM_SCRATCH > 8) begin : g_bad_scratch
         $error("sysid_regs: NUM_SCRATCH must be in 1..8");
      end
      if (ADDR_W < 4) begin : g_bad_addr
         $error("sysid_regs: ADDR_W must be >= 4");
      end
   endgenerate

   logic [31:0] addr_w;
   logic        wr_clr;
   logic        wr_lock;
   logic        rd_up_lo;
   logic        scratch_wr_ok;
   logic [31:0] lock_rd;

   logic [63:0] uptime_q, uptime_d;
   logic [31:0] snap_q, snap_d;
   logic [31:0] readdata_q, readdata_d;
   logic        rdv_q, rdv_d;
   logic [31:0] scratch_q [NUM_SCRATCH];
   logic [31:0] scratch_d [NUM_SCRATCH];
   logic [31:0] rdata_mux;

   assign addr_w   = 32'(bus.address);
   assign wr_clr   = bus.write && (addr_w == A_CLR);
   assign wr_lock  = bus.write && (addr_w == A_LOCK);
   assign rd_up_lo = bus.read  && (addr_w == A_UP_LO);

`ifdef SYSID_SCRATCH_LOCK_EN
   logic unlocked_q, unlocked_d;

   assign unlocked_d    = wr_lock ? (bus.writedata == UNLOCK_KEY) : unlocked_q;
   assign scratch_wr_ok = unlocked_q;
   assign lock_rd       = {31'h0, unlocked_q};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) unlocked_q <= 1'b0;
      else          unlocked_q <= unlocked_d;
   end
`else
   assign scratch_wr_ok = 1'b1;
   assign lock_rd       = 32'h0;
`endif

   // Snapshot captures the high word on the same edge the low word is returned,
   // so a later UP_HI read pairs with it even across a low-word carry.
   assign uptime_d = wr_clr ? 64'd0 : uptime_q + 64'd1;
   assign snap_d   = rd_up_lo ? uptime_q[63:32] : snap_q;

   always_comb begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         scratch_d[i] = scratch_q[i];
         if (bus.write && scratch_wr_ok && (addr_w == A_SCR + 32'(i)))
            scratch_d[i] = bus.writedata;
      end
   end

   always_comb begin
      rdata_mux = 32'h0;
      case (addr_w)
         A_ID:    rdata_mux = SYSTEM_ID;
         A_TS:    rdata_mux = TIMESTAMP;
         A_UP_LO: rdata_mux = uptime_q[31:0];
         A_UP_HI: rdata_mux = snap_q;
         A_CAPS:  rdata_mux = CAPS_WORD;
         A_LOCK:  rdata_mux = lock_rd;
         default: rdata_mux = 32'h0;
      endcase
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         if (addr_w == A_SCR + 32'(i)) rdata_mux = scratch_q[i];
      end
   end

   assign readdata_d = bus.read ? rdata_mux : readdata_q;
   assign rdv_d      = bus.read;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         uptime_q   <= 64'd0;
         snap_q     <= 32'h0;
         readdata_q <= 32'h0;
         rdv_q      <= 1'b0;
         for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= 32'h0;
      end else begin
         uptime_q   <= uptime_d;
         snap_q     <= snap_d;
         readdata_q <= readdata_d;
         rdv_q      <= rdv_d;
         for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
      end
   end

   assign bus.readdata      = readdata_q;
   assign bus.readdatavalid = rdv_q;

endmodule

// File: doc/sysid_regs.md
Name: sysid_regs

Overview:
- Parametrised system-identification slave, the next generation of the fixed two-word ID block.
- Returns a build-time system ID and timestamp as before. Adds:
  - a 64-bit free-running uptime counter with atomic high-word snapshot,
  - a capability word,
  - a bank of read/write scratch registers.
- Sits on the Avalon-MM control interconnect next to the CPU. Uses registered reads with readdatavalid.

Parameters:
- SYSTEM_ID, 32'h0000_0001, value returned at word 0
- TIMESTAMP, 32'h56A6_A3EC, build timestamp returned at word 1
- NUM_SCRATCH, 4, number of 32-bit scratch registers; legal range 1..8
- ADDR_W, 4, word-address width; must be >= 4

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  word address
- read  in  1  read strobe, one cycle per access
- write  in  1  write strobe, one cycle per access
- writedata  in  32  write data
- readdata  out  32  registered read data
- readdatavalid  out  1  high for exactly one cycle when readdata is valid

Behaviour:
- Interface: one clock domain. Reset is asynchronous and active-low on reset_n.
- Reset values: readdata=0, readdatavalid=0, uptime=0, snapshot=0, all scratch=0, lock=locked.
- Address map (word addresses):
  - 0 ID: RO, SYSTEM_ID.
  - 1 TS: RO, TIMESTAMP.
  - 2 UP_LO: RO, uptime[31:0].
  - 3 UP_HI: RO, snapshot.
  - 4 CAPS: RO, {16'h0, 8'(NUM_SCRATCH), 7'h0, LOCK_FEATURE}.
  - 5 CLR: WO. Any write clears uptime.
  - 6 LOCK: RW, see Optional Feature.
  - 8..8+NUM_SCRATCH-1: scratch, RW.
  - All other addresses: reads return 0, writes are ignored.
- Read latency is fixed at 1:
  - read high in cycle N -> readdata and readdatavalid=1 in cycle N+1.
  - readdatavalid=0 otherwise.
  - readdata holds its last value between reads.
  - Back-to-back reads are supported every cycle.
- Uptime:
  - 64-bit counter, +1 every clock, wraps 2^64-1 -> 0 silently.
  - A read of UP_LO returns the counter low word sampled in cycle N. In the same edge, counter[63:32] from cycle N is loaded into snapshot.
  - UP_HI returns snapshot, never the live high word. Software pairs are therefore atomic across a low-word carry.
- CLR write in cycle N:
  - counter=0 at edge N+1, 1 at N+2, and so on.
  - snapshot is unaffected.
- Writes:
  - Take effect at the rising edge of the cycle in which write is high.
  - No byte enables; full 32-bit writes only.
  - Writes to RO addresses are ignored.
- Simultaneous read and write (illegal on this bus):
  - The write takes effect.
  - The read returns the pre-write value.
  - readdatavalid is still issued.
- Reset mid-operation: asserting reset_n low clears all state immediately. A read pending when reset asserts produces no readdatavalid.

Optional Feature:
- Macro: SYSID_SCRATCH_LOCK_EN.
- Defined (CAPS[0]=1):
  - LOCK register controls scratch writes.
  - Writing 32'h4C4F_434B unlocks; writing any other value locks.
  - LOCK reads 1 when unlocked, 0 when locked.
  - Reset state is locked. Scratch writes while locked are ignored.
- Undefined (CAPS[0]=0):
  - Scratch is always writable.
  - LOCK reads 0; writes to LOCK are ignored.
  - No lock flop is instantiated.

Test Plan:
- Reset, then read addresses 0,1,4 back-to-back -> readdata 32'h0000_0001, 32'h56A6_A3EC, 32'h0000_0400 (lock disabled). readdatavalid high in each following cycle.
- Force uptime to 64'h0000_0000_FFFF_FFFE, read UP_LO, then read UP_HI 5 cycles later -> readdata 32'hFFFF_FFFE then 32'h0000_0000. The carry does not leak into the snapshot.
- Write CLR in cycle N, read UP_LO in cycle N+3 -> readdata 2.
- NUM_SCRATCH=4: write 32'hDEAD_BEEF to word 9, read 9 -> 32'hDEAD_BEEF. Write to word 12, read 12 -> 0. Read word 7 -> 0.
- With SYSID_SCRATCH_LOCK_EN:
  - Write 32'h1234 to word 8 -> reads 0.
  - Write 32'h4C4F_434B to LOCK, then write 32'h1234 to word 8 -> reads 32'h1234. LOCK reads 1.
  - Write 0 to LOCK -> LOCK reads 0; a further scratch write is ignored.
- Assert reset_n low for 1 cycle after writing scratch and with a read pending -> no readdatavalid. Scratch, uptime and readdata read back 0.
